// File: rtl/mmap_arbiter.sv
// Two-requester round-robin arbiter in front of a single command/response target.
// One transaction is in flight at a time, and a read that gets no answer times out.
module mmap_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_new_cmd,
    input  logic        a_write,
    input  logic [5:0]  a_cmd,
    input  logic [31:0] a_address,
    input  logic [31:0] a_data,
    output logic        a_busy,
    output logic [31:0] a_rdata,
    output logic        a_drdy,

    input  logic        b_new_cmd,
    input  logic        b_write,
    input  logic [5:0]  b_cmd,
    input  logic [31:0] b_address,
    input  logic [31:0] b_data,
    output logic        b_busy,
    output logic [31:0] b_rdata,
    output logic        b_drdy,

    output logic        t_new_cmd,
    output logic        t_write,
    output logic [5:0]  t_cmd,
    output logic [31:0] t_address,
    output logic [31:0] t_data,
    input  logic        t_busy,
    input  logic [31:0] t_rdata,
    input  logic        t_drdy,

    output logic        grant,
    output logic        timeout_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_READ
    } state_t;

    state_t             state_q;
    logic               prio_q;
    logic               grant_q;
    logic               t_new_cmd_q;
    logic               t_write_q;
    logic [5:0]         t_cmd_q;
    logic [31:0]        t_address_q;
    logic [31:0]        t_data_q;
    logic               timeout_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Requesters gathered into index-0 = A, index-1 = B form.
    logic [1:0]         req_new_cmd;
    logic [1:0]         req_write;
    logic [5:0]         req_cmd     [2];
    logic [31:0]        req_address [2];
    logic [31:0]        req_data    [2];

    assign req_new_cmd    = {b_new_cmd, a_new_cmd};
    assign req_write      = {b_write, a_write};
    assign req_cmd[0]     = a_cmd;
    assign req_cmd[1]     = b_cmd;
    assign req_address[0] = a_address;
    assign req_address[1] = b_address;
    assign req_data[0]    = a_data;
    assign req_data[1]    = b_data;

    logic               sel_new_cmd;
    logic               sel_write;
    logic [5:0]         sel_cmd;
    logic [31:0]        sel_address;
    logic [31:0]        sel_data;

    assign sel_new_cmd = req_new_cmd[prio_q];
    assign sel_write   = req_write[prio_q];
    assign sel_cmd     = req_cmd[prio_q];
    assign sel_address = req_address[prio_q];
    assign sel_data    = req_data[prio_q];

    // A response is delivered either on real data or on expiry; real data wins a tie.
    logic               in_wait;
    logic               resp_fire;
    logic [31:0]        resp_data;

    assign in_wait   = (state_q == ST_WAIT_READ);
    assign resp_fire = in_wait && (t_drdy || (cnt_q == CNT_LAST));
    assign resp_data = t_drdy ? t_rdata : TIMEOUT_DATA;
    assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prio_q        <= 1'b0;
            grant_q       <= 1'b0;
            t_new_cmd_q   <= 1'b0;
            t_write_q     <= 1'b0;
            t_cmd_q       <= '0;
            t_address_q   <= '0;
            t_data_q      <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            t_new_cmd_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The slot rotates every idle cycle whether or not it was taken.
                    prio_q <= ~prio_q;
                    if (sel_new_cmd) begin
                        t_write_q   <= sel_write;
                        t_cmd_q     <= sel_cmd;
                        t_address_q <= sel_address;
                        t_data_q    <= sel_data;
                        grant_q     <= prio_q;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!t_busy) begin
                        t_new_cmd_q <= 1'b1;
                        if (t_write_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_READ;
                        end
                    end
                end
                ST_WAIT_READ: begin
                    if (t_drdy) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [1:0]         busy_vec;
    logic [1:0]         drdy_vec;
    logic [31:0]        rdata_vec [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic        drdy_q;
            logic [31:0] rdata_q;

            assign busy_vec[gi] = !((state_q == ST_IDLE) && (prio_q == 1'(gi)));

            always_ff @(posedge clk) begin
                if (rst) begin
                    drdy_q  <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    drdy_q <= resp_fire && (grant_q == 1'(gi));
                    if (resp_fire && (grant_q == 1'(gi))) begin
                        rdata_q <= resp_data;
                    end
                end
            end

            assign drdy_vec[gi]  = drdy_q;
            assign rdata_vec[gi] = rdata_q;
        end
    endgenerate

    assign a_busy      = busy_vec[0];
    assign b_busy      = busy_vec[1];
    assign a_drdy      = drdy_vec[0];
    assign b_drdy      = drdy_vec[1];
    assign a_rdata     = rdata_vec[0];
    assign b_rdata     = rdata_vec[1];

    assign t_new_cmd   = t_new_cmd_q;
    assign t_write     = t_write_q;
    assign t_cmd       = t_cmd_q;
    assign t_address   = t_address_q;
    assign t_data      = t_data_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mmap_arbiter.sv
// Scoreboard bench for mmap_arbiter: stimulus queues expected target commands and
// read responses, and a negedge monitor pops and compares them as the DUT emits them.
module tb_mmap_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_new_cmd = 1'b0, a_write = 1'b0;
    logic [5:0]  a_cmd = '0;
    logic [31:0] a_address = '0, a_data = '0;
    logic        b_new_cmd = 1'b0, b_write = 1'b0;
    logic [5:0]  b_cmd = '0;
    logic [31:0] b_address = '0, b_data = '0;
    logic        a_busy, b_busy, a_drdy, b_drdy;
    logic [31:0] a_rdata, b_rdata;
    logic        t_new_cmd, t_write;
    logic [5:0]  t_cmd;
    logic [31:0] t_address, t_data;
    logic        t_busy = 1'b0;
    logic [31:0] t_rdata = '0;
    logic        t_drdy = 1'b0;
    logic        grant, timeout_err;

    mmap_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_DATA  (32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .a_new_cmd(a_new_cmd), .a_write(a_write), .a_cmd(a_cmd), .a_address(a_address),
        .a_data(a_data), .a_busy(a_busy), .a_rdata(a_rdata), .a_drdy(a_drdy),
        .b_new_cmd(b_new_cmd), .b_write(b_write), .b_cmd(b_cmd), .b_address(b_address),
        .b_data(b_data), .b_busy(b_busy), .b_rdata(b_rdata), .b_drdy(b_drdy),
        .t_new_cmd(t_new_cmd), .t_write(t_write), .t_cmd(t_cmd), .t_address(t_address),
        .t_data(t_data), .t_busy(t_busy), .t_rdata(t_rdata), .t_drdy(t_drdy),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic [5:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        owner;
    } cmd_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic        terr;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command on one requester and hold it until the arbiter takes it.
    task automatic req(input bit who, input bit wr, input logic [5:0] c,
                       input logic [31:0] ad, input logic [31:0] dt, input bit push);
        int waited = 0;
        if (who == 1'b0) begin
            a_write = wr; a_cmd = c; a_address = ad; a_data = dt; a_new_cmd = 1'b1;
        end else begin
            b_write = wr; b_cmd = c; b_address = ad; b_data = dt; b_new_cmd = 1'b1;
        end
        while ((who ? b_busy : a_busy) && waited < 50) begin
            tick();
            waited++;
        end
        check("req_slot_within_bound", waited < 50, 1);
        tick();
        if (who == 1'b0) a_new_cmd = 1'b0;
        else             b_new_cmd = 1'b0;
        if (push) cmd_q.push_back('{wr, c, ad, dt, who});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_t_new_cmd"}, t_new_cmd, 0);
        check({tag, "_t_fields"}, {t_write, t_cmd, t_address, t_data}, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
        check({tag, "_pulses"}, {a_drdy, b_drdy, timeout_err}, 0);
        check({tag, "_busy_ab"}, {a_busy, b_busy}, 2'b01);
    endtask

    // Monitor: every target command and every read response is matched against the queues.
    cmd_t mon_c;
    rsp_t mon_r;
    always @(negedge clk) begin
        if (t_new_cmd === 1'b1) begin
            $display("t_cmd   w=%0d cmd=%0h addr=%08h data=%08h grant=%0d",
                     t_write, t_cmd, t_address, t_data, grant);
            check("t_cmd_was_expected", cmd_q.size() != 0, 1);
            if (cmd_q.size() != 0) begin
                mon_c = cmd_q.pop_front();
                check("t_cmd_fields", {t_write, t_cmd, t_address, t_data, grant}, mon_c);
            end
        end
        if (a_drdy === 1'b1 || b_drdy === 1'b1) begin
            $display("rsp     a_drdy=%0d b_drdy=%0d a_rdata=%08h b_rdata=%08h terr=%0d",
                     a_drdy, b_drdy, a_rdata, b_rdata, timeout_err);
            check("rsp_single_owner", a_drdy & b_drdy, 0);
            check("rsp_was_expected", rsp_q.size() != 0, 1);
            if (rsp_q.size() != 0) begin
                mon_r = rsp_q.pop_front();
                check("rsp_fields", {b_drdy, (b_drdy ? b_rdata : a_rdata), timeout_err}, mon_r);
            end
        end else if (timeout_err === 1'b1) begin
            check("timeout_err_without_drdy", timeout_err, 0);
        end
    end

    initial begin
        int k;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;

        // A single write and its issue latency.
        req(0, 1, 6'h01, 32'h10, 32'h12345678, 1);
        check("t1_no_issue_on_accept", t_new_cmd, 0);
        tick();
        check("t1_t_new_cmd", t_new_cmd, 1);
        check("t1_t_fields", {t_write, t_address, t_data}, {1'b1, 32'h10, 32'h12345678});
        k = 0;
        while (a_busy && k < 2) begin tick(); k++; end
        check("t1_a_busy_low_in_2", a_busy, 0);

        // Two continuously requesting masters alternate strictly.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_q.push_back('{1'b1, 6'h01, 32'(i), 32'hA000_0000 + 32'(i), 1'b0});
            cmd_q.push_back('{1'b1, 6'h02, 32'h100 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1});
        end
        fork
            for (int i = 0; i < 4; i++) req(0, 1, 6'h01, 32'(i), 32'hA000_0000 + 32'(i), 0);
            for (int j = 0; j < 4; j++) req(1, 1, 6'h02, 32'h100 + 32'(j), 32'hB000_0000 + 32'(j), 0);
        join
        repeat (2) tick();
        check("t2_order_drained", cmd_q.size(), 0);

        // B read answered after 5 cycles.
        req(1, 0, 6'h03, 32'h20, 32'h0, 1);
        rsp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0});
        tick();
        check("t3_t_new_cmd", t_new_cmd, 1);
        repeat (4) tick();
        t_rdata = 32'hCAFEF00D; t_drdy = 1'b1;
        tick();
        t_drdy = 1'b0; t_rdata = 32'h0;
        check("t3_b_drdy", b_drdy, 1);
        check("t3_b_rdata", b_rdata, 32'hCAFEF00D);
        check("t3_a_drdy", a_drdy, 0);
        check("t3_grant", grant, 1);
        tick();
        check("t3_b_drdy_one_cycle", b_drdy, 0);
        check("t3_b_rdata_holds", b_rdata, 32'hCAFEF00D);

        // A read to a dead target times out.
        req(0, 0, 6'h04, 32'h30, 32'h0, 1);
        rsp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b1});
        tick();
        check("t4_t_new_cmd", t_new_cmd, 1);
        k = 0;
        while (!a_drdy && k < 40) begin tick(); k++; end
        check("t4_timeout_latency", k, TO);
        check("t4_timeout_err", timeout_err, 1);
        check("t4_a_rdata", a_rdata, 32'hDEADBEEF);
        req(0, 1, 6'h05, 32'h40, 32'h55AA55AA, 1);
        tick();
        check("t4_write_after_timeout", t_new_cmd, 1);
        t_rdata = 32'h0BAD0BAD; t_drdy = 1'b1;
        tick();
        t_drdy = 1'b0;
        repeat (3) begin
            tick();
            check("t4_late_t_drdy_ignored", {a_drdy, b_drdy}, 0);
        end

        // Target busy during issue.
        t_busy = 1'b1;
        req(0, 1, 6'h06, 32'h50, 32'hA5A5A5A5, 1);
        for (int i = 0; i < 10; i++) begin
            check("t5_no_issue_while_busy", t_new_cmd, 0);
            check("t5_both_busy", {a_busy, b_busy}, 2'b11);
            check("t5_fields_stable", {t_write, t_cmd, t_address, t_data},
                  {1'b1, 6'h06, 32'h50, 32'hA5A5A5A5});
            tick();
        end
        t_busy = 1'b0;
        tick();
        check("t5_issue_after_busy_drop", t_new_cmd, 1);
        tick();

        // Reset in the middle of a read; the late answer must vanish.
        req(0, 0, 6'h07, 32'h60, 32'h0, 1);
        tick();
        check("t6_t_new_cmd", t_new_cmd, 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_reset("t6_reset");
        rst = 1'b0;
        repeat (2) tick();
        t_rdata = 32'h11112222; t_drdy = 1'b1;
        tick();
        t_drdy = 1'b0;
        repeat (3) begin
            tick();
            check("t6_no_drdy_after_reset", {a_drdy, b_drdy}, 0);
        end

        repeat (2) tick();
        check("end_cmd_queue_empty", cmd_q.size(), 0);
        check("end_rsp_queue_empty", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
